// File: rtl/pixie_dma_ctrl.sv
// CDP1802-side DMA/interrupt sequencer for the Pixie display path.
// Grants DMAO/INT at machine-cycle boundaries, drives SC, and owns the R0 DMA pointer.
//   state | meaning
//   IDLE  | CPU owns the bus (SC=01)
//   DMA   | S2 cycle: R0 read fed to Pixie (SC=10)
//   INTR  | S3 cycle: interrupt acknowledge (SC=11)
//   YIELD | forced CPU cycle after a full burst (SC=01)
module pixie_dma_ctrl #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] R0_RESET  = '0,
  parameter int                MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic              cpu_boundary,
  input  logic              ie,
  input  logic              DMAO,
  input  logic              INT,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_din,
  input  logic [7:0]        mem_data,
  output logic [1:0]        SC,
  output logic              cpu_hold,
  output logic              ie_clr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] r0,
  output logic [3:0]        burst_cnt
);

  typedef enum logic [1:0] {IDLE, DMA, INTR, YIELD} state_t;

  localparam logic [1:0] SC_S1 = 2'b01;
  localparam logic [1:0] SC_S2 = 2'b10;
  localparam logic [1:0] SC_S3 = 2'b11;

  state_t            state;
  logic [ADDR_W-1:0] r0_inc;
  logic              burst_ok;

  assign r0_inc   = r0 + ADDR_W'(1);
  assign burst_ok = (MAX_BURST == 0) || (({28'd0, burst_cnt} + 32'd1) < 32'(MAX_BURST));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      SC        <= SC_S1;
      cpu_hold  <= 1'b0;
      ie_clr    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      data_out  <= '0;
      r0        <= R0_RESET;
      burst_cnt <= '0;
    end else begin
      mem_rd <= 1'b0;
      ie_clr <= 1'b0;
      // RAM answers in the clk after the strobe; the byte then holds until the Pixie samples it
      if (mem_rd)
        data_out <= mem_data;
      if (state == IDLE && r0_we)
        r0 <= r0_din;

      if (clk_enable) begin
        case (state)
          IDLE: begin
            if (cpu_boundary && DMAO) begin
              state    <= DMA;
              SC       <= SC_S2;
              cpu_hold <= 1'b1;
              mem_addr <= r0;
              mem_rd   <= 1'b1;
            end else if (cpu_boundary && INT && ie) begin
              state    <= INTR;
              SC       <= SC_S3;
              cpu_hold <= 1'b1;
              ie_clr   <= 1'b1;
            end
          end

          DMA: begin
            r0        <= r0_inc;
            burst_cnt <= burst_cnt + 4'd1;
            if (DMAO && burst_ok) begin
              mem_addr <= r0_inc;
              mem_rd   <= 1'b1;
            end else begin
              state     <= DMAO ? YIELD : IDLE;
              SC        <= SC_S1;
              cpu_hold  <= 1'b0;
              burst_cnt <= '0;
            end
          end

          YIELD: begin
            if (DMAO) begin
              state    <= DMA;
              SC       <= SC_S2;
              cpu_hold <= 1'b1;
              mem_addr <= r0;
              mem_rd   <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end

          INTR: begin
            if (DMAO && cpu_boundary) begin
              state    <= DMA;
              SC       <= SC_S2;
              cpu_hold <= 1'b1;
              mem_addr <= r0;
              mem_rd   <= 1'b1;
            end else begin
              state    <= IDLE;
              SC       <= SC_S1;
              cpu_hold <= 1'b0;
            end
          end

          default: begin
            state    <= IDLE;
            SC       <= SC_S1;
            cpu_hold <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixie_dma_ctrl.sv
// Directed bench for pixie_dma_ctrl: bursts, burst limit, R0 wrap, interrupt gating and reset abort.
// One machine cycle is four clks with clk_enable on the first.
module tb_pixie_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset, clk_enable, cpu_boundary, ie, DMAO, INT, r0_we;
  logic [15:0] r0_din;
  logic [7:0]  mem_data;
  logic [1:0]  SC;
  logic        cpu_hold, ie_clr, mem_rd;
  logic [15:0] mem_addr, r0;
  logic [7:0]  data_out;
  logic [3:0]  burst_cnt;

  int checks = 0;
  int errors = 0;

  pixie_dma_ctrl dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .cpu_boundary(cpu_boundary),
    .ie(ie), .DMAO(DMAO), .INT(INT), .r0_we(r0_we), .r0_din(r0_din),
    .mem_data(mem_data), .SC(SC), .cpu_hold(cpu_hold), .ie_clr(ie_clr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .data_out(data_out), .r0(r0),
    .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // RAM drives data only while the strobe is up, so late or early capture shows as 8'hEE
  assign mem_data = mem_rd ? ram_val(mem_addr) : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ce_edge();
    clk_enable = 1'b1;
    @(posedge clk);
    #1;
    clk_enable = 1'b0;
  endtask

  task automatic chk_idle(input string tag, input logic [15:0] exp_r0);
    chk({tag, "_sc"}, SC, 2'b01);
    chk({tag, "_hold"}, cpu_hold, 1'b0);
    chk({tag, "_rd"}, mem_rd, 1'b0);
    chk({tag, "_r0"}, r0, exp_r0);
    chk({tag, "_burst"}, burst_cnt, 4'd0);
  endtask

  // One DMA cycle: grant edge, then data edge, then the rest of the machine cycle
  task automatic chk_dma(input string tag, input logic [15:0] addr, input logic [3:0] bc);
    chk({tag, "_sc"}, SC, 2'b10);
    chk({tag, "_hold"}, cpu_hold, 1'b1);
    chk({tag, "_rd"}, mem_rd, 1'b1);
    chk({tag, "_addr"}, mem_addr, addr);
    chk({tag, "_burst"}, burst_cnt, bc);
    clks(1);
    chk({tag, "_rd_off"}, mem_rd, 1'b0);
    chk({tag, "_data"}, data_out, ram_val(addr));
    chk({tag, "_r0"}, r0, addr);
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b0; cpu_boundary = 1'b0; ie = 1'b0;
    DMAO = 1'b0; INT = 1'b0; r0_we = 1'b0; r0_din = '0;
    clks(2);
    chk_idle("rst", 16'h0000);
    chk("rst_ieclr", ie_clr, 1'b0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_data", data_out, 8'h00);
    reset = 1'b0;

    // 8-byte burst from 0x0900, DMAO dropped before the limit is hit
    r0_we = 1'b1; r0_din = 16'h0900;
    clks(1);
    r0_we = 1'b0;
    chk("t1_load", r0, 16'h0900);
    DMAO = 1'b1; cpu_boundary = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ce_edge();
      chk_dma("t1", 16'h0900 + 16'(i), 4'(i));
      if (i == 3) begin
        r0_we = 1'b1; r0_din = 16'hABCD;
        clks(1);
        r0_we = 1'b0;
        chk("t1_we_ignored", r0, 16'h0903);
        clks(1);
      end else begin
        clks(2);
      end
      if (i == 7) DMAO = 1'b0;
    end
    ce_edge();
    chk_idle("t1_end", 16'h0908);
    clks(3);

    // burst limit: 8 DMA, 1 YIELD, 4 DMA
    DMAO = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ce_edge();
      chk_dma("t3a", 16'h0908 + 16'(i), 4'(i));
      clks(2);
    end
    ce_edge();
    chk_idle("t3_yield", 16'h0910);
    clks(3);
    for (int i = 0; i < 4; i++) begin
      ce_edge();
      chk_dma("t3b", 16'h0910 + 16'(i), 4'(i));
      clks(2);
      if (i == 3) DMAO = 1'b0;
    end
    ce_edge();
    chk_idle("t3_end", 16'h0914);
    clks(3);

    // DMAO beats INT; INTR only once DMAO is gone
    ie = 1'b1; INT = 1'b1; DMAO = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ce_edge();
      chk("t2_ieclr_dma", ie_clr, 1'b0);
      chk_dma("t2", 16'h0914 + 16'(i), 4'(i));
      clks(2);
    end
    DMAO = 1'b0;
    ce_edge();
    chk_idle("t2_dma_end", 16'h0916);
    chk("t2_ieclr_idle", ie_clr, 1'b0);
    clks(3);
    ce_edge();
    chk("t2_intr_sc", SC, 2'b11);
    chk("t2_intr_hold", cpu_hold, 1'b1);
    chk("t2_intr_ieclr", ie_clr, 1'b1);
    chk("t2_intr_rd", mem_rd, 1'b0);
    clks(1);
    chk("t2_ieclr_pulse", ie_clr, 1'b0);
    chk("t2_intr_sc2", SC, 2'b11);
    ie = 1'b0;
    clks(2);
    ce_edge();
    chk_idle("t2_intr_end", 16'h0916);
    clks(3);

    // INT with IE clear is held off until IE rises
    for (int i = 0; i < 2; i++) begin
      ce_edge();
      chk_idle("t5_masked", 16'h0916);
      chk("t5_ieclr_masked", ie_clr, 1'b0);
      clks(3);
    end
    ie = 1'b1;
    ce_edge();
    chk("t5_intr_sc", SC, 2'b11);
    chk("t5_intr_ieclr", ie_clr, 1'b1);
    clks(1);
    chk("t5_ieclr_pulse", ie_clr, 1'b0);
    ie = 1'b0; INT = 1'b0;
    clks(2);
    ce_edge();
    chk_idle("t5_end", 16'h0916);
    clks(3);

    // R0 wrap through FFFF
    r0_we = 1'b1; r0_din = 16'hFFFE;
    clks(1);
    r0_we = 1'b0;
    DMAO = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ce_edge();
      chk_dma("t4", 16'hFFFE + 16'(i), 4'(i));
      clks(2);
      if (i == 2) DMAO = 1'b0;
    end
    ce_edge();
    chk_idle("t4_end", 16'h0001);
    clks(3);

    // reset in the 4th DMA cycle aborts the burst
    r0_we = 1'b1; r0_din = 16'h1230;
    clks(1);
    r0_we = 1'b0;
    DMAO = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ce_edge();
      chk_dma("t6", 16'h1230 + 16'(i), 4'(i));
      clks(2);
    end
    ce_edge();
    chk("t6_4th_addr", mem_addr, 16'h1233);
    reset = 1'b1;
    clks(1);
    chk_idle("t6_rst", 16'h0000);
    chk("t6_rst_addr", mem_addr, 16'h0000);
    chk("t6_rst_data", data_out, 8'h00);
    clks(2);
    ce_edge();
    chk("t6_rst_hold_r0", r0, 16'h0000);
    reset = 1'b0; DMAO = 1'b0;
    clks(3);
    ce_edge();
    chk_idle("t6_after", 16'h0000);
    clks(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixie_dma_ctrl.md
Name: pixie_dma_ctrl

Overview:
- CDP1802-side DMA/interrupt sequencer that feeds the Pixie display stage.
- Arbitrates Pixie DMAO and INT requests against the CPU at machine-cycle boundaries.
- Drives the SC state code and owns the R0 DMA pointer.
- Fetches display bytes from RAM and presents them as the data the Pixie samples during S2 (DMA) cycles.

Parameters:
- ADDR_W, 16, width of R0 and memory address.
- R0_RESET, 16'h0000, R0 value after reset.
- MAX_BURST, 8, max DMA bytes per burst before one forced CPU machine cycle; 0 = unlimited.

Ports:
- clk  in  1  CDP1802 bus clock
- reset  in  1  synchronous, active-high
- clk_enable  in  1  one pulse per machine cycle; all state changes gated by it
- cpu_boundary  in  1  CPU at end of S1/S2 this machine cycle (DMA/INT grant point)
- ie  in  1  CPU interrupt-enable flag
- DMAO  in  1  Pixie DMA-out request
- INT  in  1  Pixie interrupt request
- r0_we  in  1  CPU write strobe to R0
- r0_din  in  ADDR_W  CPU write data for R0
- mem_data  in  8  RAM read data, valid one clk after mem_rd
- SC  out  2  state code: 00 S0, 01 S1 (CPU-owned), 10 S2 DMA, 11 S3 INT
- cpu_hold  out  1  CPU must stall this machine cycle
- ie_clr  out  1  one-cycle pulse: CPU clears IE, saves X/P
- mem_addr  out  ADDR_W  RAM address (R0 during DMA)
- mem_rd  out  1  RAM read strobe, one clk wide
- data_out  out  8  byte presented to Pixie data_in
- r0  out  ADDR_W  current R0
- burst_cnt  out  4  bytes transferred in current burst

Behaviour:
- Reset (sync, highest priority):
  - state=IDLE, SC=01, cpu_hold=0, ie_clr=0, mem_rd=0, mem_addr=0, data_out=0, r0=R0_RESET, burst_cnt=0.
  - Reset mid-burst aborts with no further R0 increment.
- States: IDLE, DMA, INTR, YIELD. Transitions only on clk_enable=1.
- IDLE:
  - If cpu_boundary & DMAO -> DMA.
  - Else if cpu_boundary & INT & ie -> INTR.
  - DMAO has priority over INT when both are pending.
  - Without cpu_boundary, requests are held pending, not latched.
- DMA entry (same clk_enable):
  - SC<=10, cpu_hold<=1, mem_addr<=r0, mem_rd<=1 for one clk.
  - Next clk: data_out<=mem_data; data_out then holds stable until the next clk_enable, at which the Pixie samples it.
  - On the clk_enable that ends each DMA cycle: r0<=r0+1, wrapping FFFF->0000; burst_cnt<=burst_cnt+1.
  - Then:
    - If DMAO is still 1 and (MAX_BURST==0 or burst_cnt+1<MAX_BURST), stay in DMA and issue the next read.
    - Else if DMAO is still 1 (limit reached) -> YIELD.
    - Else -> IDLE.
- YIELD:
  - One machine cycle: SC=01, cpu_hold=0.
  - Then -> DMA if DMAO, else IDLE.
  - burst_cnt clears on entry to YIELD or IDLE.
- INTR:
  - One machine cycle: SC=11, cpu_hold=1, ie_clr pulses for one clk at entry, no memory access.
  - Then -> DMA if DMAO & cpu_boundary, else IDLE.
  - INT is level-sensitive; the CPU clearing IE prevents re-entry.
- R0 write:
  - r0_we in IDLE loads r0_din on any clk, no clk_enable needed.
  - r0_we during DMA/INTR is ignored (CPU is held).
  - Same-cycle r0_we and DMA increment: the increment wins.
- SC=01 whenever the CPU owns the bus; mem_rd is never 1 outside DMA.
- Latency:
  - Request to first SC=10: ≤1 machine cycle after cpu_boundary.
  - mem_rd to data_out: 1 clk.

Test Plan:
1. Reset, r0_we=1 r0_din=0x0900; DMAO high for 8 boundaries of clk_enable, cpu_boundary=1 -> 8 consecutive SC=10 cycles, mem_addr 0900..0907, data_out matches RAM, r0=0x0908, then SC=01.
2. DMAO and INT asserted together, ie=1 -> DMA cycles first; INTR (SC=11, ie_clr single pulse) only after DMAO drops.
3. MAX_BURST=8, DMAO held 12 cycles -> 8 DMA cycles, 1 YIELD cycle (SC=01, cpu_hold=0), 4 more DMA cycles; r0 advances by 12.
4. r0=0xFFFE, 3-byte burst -> addresses FFFE, FFFF, 0000; r0 ends 0x0001.
5. INT=1, ie=0 -> stays IDLE, SC=01, no ie_clr; raise ie -> one INTR cycle at next boundary.
6. Assert reset during the 4th DMA cycle -> next clk: SC=01, cpu_hold=0, mem_rd=0, r0=R0_RESET, burst_cnt=0.
